m_pte_responder: RTL
====================

// Module: m_pte_responder
// PURPOSE
//  Services the page walker's PTE accesses (L1/L0 PTE reads, A/D write-backs) toward DRAM.
//  Sits between the MMU page walker and the DRAM controller port used for PTE traffic.
//  Converts a request strobe into a single DRAM transaction and returns data with a busy handshake.
//  Optional small direct-mapped PTE cache cuts repeat page-walk latency.
// PARAMETERS
//  PTE_CACHE_SIZE  16    cache entries; power of 2, >=2; unused without PTE_CACHE_EN
//  TIMEOUT         1024  max cycles in WAIT before abort; >=2
// PORTS
//  CLK            in   1   clock; all logic on posedge
//  RST            in   1   reset; synchronous, active-high
//  w_pte_req      in   1   request strobe; sampled only in IDLE
//  w_pte_we       in   1   1 = PTE write, 0 = PTE read; sampled with req
//  w_pte_addr     in   32  PTE byte address; bits [1:0] ignored and forced to 0
//  w_pte_wdata    in   32  PTE write data; sampled with req
//  w_pte_flush    in   1   sfence.vma / satp write; invalidates all cache entries
//  r_pte_busy     out  1   high from cycle after acceptance until response done
//  r_pte_rdata    out  32  read data; valid from first cycle busy is low after a read
//  r_pte_err      out  1   one-cycle pulse on timeout abort
//  r_dram_req     out  1   one-cycle DRAM command pulse
//  r_dram_we      out  1   DRAM write enable; qualified by r_dram_req
//  r_dram_addr    out  32  DRAM word address, {addr[31:2],2'b0}
//  r_dram_wdata   out  32  DRAM write data
//  w_dram_busy    in   1   DRAM busy; rises the cycle after r_dram_req, falls when done
//  w_dram_odata   in   32  DRAM read data; valid in the cycle w_dram_busy is low in WAIT
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; cache valid bits 0; timeout counter 0.
//  FSM: IDLE, HIT, ISSUE, WAIT.
//   IDLE:  req=1 -> latch we/addr/wdata; busy<=1; read hit -> HIT; otherwise -> ISSUE.
//   HIT:   rdata<=cache data; busy<=0; -> IDLE. Read-hit latency: busy high exactly 1 cycle.
//   ISSUE: dram_req=1 with latched addr/we/wdata; counter<=0; -> WAIT.
//   WAIT:  !w_dram_busy -> on read, rdata<=w_dram_odata; busy<=0; -> IDLE.
//          counter==TIMEOUT-1 and still busy -> rdata<=0 (V=0, walker faults); err pulse;
//          busy<=0; -> IDLE.
//  Miss latency: busy high for ISSUE + all WAIT cycles; minimum 2 cycles.
//  r_pte_rdata holds its value until the next read completes; writes leave it unchanged.
//  req while busy is ignored; the requester holds req only while busy is low.
//  Simultaneous DRAM done and timeout in WAIT: done wins, no err.
//  RST mid-transaction: back to IDLE next cycle; an in-flight DRAM op is not tracked.
// CONFIGURATION
//  PTE_CACHE_EN defined: direct-mapped, index addr[IW+1:2], tag addr[31:IW+2],
//   IW=log2(PTE_CACHE_SIZE).
//   Read miss fills the entry on completion; a write always goes to DRAM (write-through)
//   and updates/allocates the entry in ISSUE.
//   flush clears all valid bits next cycle and beats any same-cycle fill.
//   A flush during WAIT suppresses the fill of that read.
//   A flush with req in IDLE makes that request a miss.
//  PTE_CACHE_EN undefined: no cache storage; every request goes IDLE->ISSUE->WAIT;
//   HIT unreachable; w_pte_flush ignored.
// TESTING
//  Read miss: req rd 0x8000_1004, DRAM busy 3 cycles, odata 0x2000_00CF ->
//   one dram_req, addr 0x8000_1004, we=0; rdata=0x2000_00CF when busy falls.
//  (CACHE_EN) Repeat read 0x8000_1004 -> no dram_req; busy high 1 cycle; rdata=0x2000_00CF.
//  Write: req wr 0x8000_1007, wdata 0x2000_00DF -> dram_addr 0x8000_1004, we=1;
//   a following read hits with 0x2000_00DF.
//  Flush same cycle as req rd 0x8000_1004 -> miss path taken, dram_req asserted.
//  Timeout: DRAM busy stuck, TIMEOUT=8 -> err pulse after 8 WAIT cycles;
//   rdata=0; busy low; next req accepted.
//  RST asserted during WAIT -> busy=0, dram_req=0, rdata=0 next cycle; cache empty.

Source files
------------

// File: rtl/m_pte_responder.sv
// PTE access responder between the MMU page walker and the DRAM port: one DRAM transaction per request, busy handshake.
// Define PTE_CACHE_EN to build the optional direct-mapped, write-through PTE cache.
module m_pte_responder #(
    parameter int unsigned PTE_CACHE_SIZE = 16,
    parameter int unsigned TIMEOUT        = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        w_pte_req,
    input  logic        w_pte_we,
    input  logic [31:0] w_pte_addr,
    input  logic [31:0] w_pte_wdata,
    input  logic        w_pte_flush,
    output logic        r_pte_busy,
    output logic [31:0] r_pte_rdata,
    output logic        r_pte_err,
    output logic        r_dram_req,
    output logic        r_dram_we,
    output logic [31:0] r_dram_addr,
    output logic [31:0] r_dram_wdata,
    input  logic        w_dram_busy,
    input  logic [31:0] w_dram_odata
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIT,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;

    logic          w_accept;
    logic          w_done;
    logic          w_tmo;
    logic          w_hit;
    logic [31:0]   w_cache_rdata;

    logic          w_busy_nxt;
    logic          w_err_nxt;
    logic          w_dreq_nxt;
    logic [31:0]   w_rdata_nxt;

    assign w_accept = (r_state == S_IDLE) && w_pte_req;
    assign w_done   = (r_state == S_WAIT) && !w_dram_busy;
    // Completion takes priority over the abort when both land in the same cycle.
    assign w_tmo    = (r_state == S_WAIT) && w_dram_busy && (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pte_req) begin
                    w_state_nxt = w_hit ? S_HIT : S_ISSUE;
                end
            end
            S_HIT:   w_state_nxt = S_IDLE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_done || w_tmo) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy_nxt  = r_pte_busy;
        w_err_nxt   = 1'b0;
        w_dreq_nxt  = 1'b0;
        w_rdata_nxt = r_pte_rdata;
        case (r_state)
            S_IDLE: begin
                if (w_pte_req) begin
                    w_busy_nxt = 1'b1;
                    w_dreq_nxt = !w_hit;
                end
            end
            S_HIT: begin
                w_rdata_nxt = w_cache_rdata;
                w_busy_nxt  = 1'b0;
            end
            S_WAIT: begin
                if (w_done) begin
                    if (!r_dram_we) begin
                        w_rdata_nxt = w_dram_odata;
                    end
                    w_busy_nxt = 1'b0;
                end else if (w_tmo) begin
                    w_rdata_nxt = '0;
                    w_err_nxt   = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pte_busy   <= 1'b0;
            r_pte_rdata  <= '0;
            r_pte_err    <= 1'b0;
            r_dram_req   <= 1'b0;
            r_dram_we    <= 1'b0;
            r_dram_addr  <= '0;
            r_dram_wdata <= '0;
            r_cnt        <= '0;
        end else begin
            r_pte_busy  <= w_busy_nxt;
            r_pte_rdata <= w_rdata_nxt;
            r_pte_err   <= w_err_nxt;
            r_dram_req  <= w_dreq_nxt;
            if (w_accept) begin
                r_dram_we    <= w_pte_we;
                r_dram_addr  <= {w_pte_addr[31:2], 2'b00};
                r_dram_wdata <= w_pte_wdata;
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

`ifdef PTE_CACHE_EN
    localparam int unsigned IW = $clog2(PTE_CACHE_SIZE);
    localparam int unsigned TW = 30 - IW;

    logic [PTE_CACHE_SIZE-1:0] r_valid;
    logic [TW-1:0]             r_tag   [PTE_CACHE_SIZE];
    logic [31:0]               r_cdata [PTE_CACHE_SIZE];
    logic                      r_fill_kill;

    logic [IW-1:0]             w_req_idx;
    logic [TW-1:0]             w_req_tag;
    logic [IW-1:0]             w_lat_idx;
    logic [TW-1:0]             w_lat_tag;
    logic                      w_wr_alloc;
    logic                      w_fill;
    logic                      w_unused;

    assign w_req_idx = w_pte_addr[IW+1:2];
    assign w_req_tag = w_pte_addr[31:IW+2];
    assign w_lat_idx = r_dram_addr[IW+1:2];
    assign w_lat_tag = r_dram_addr[31:IW+2];
    assign w_unused  = ^w_pte_addr[1:0];

    // A flush presented with the request forces the miss path.
    assign w_hit = !w_pte_we && !w_pte_flush && r_valid[w_req_idx]
                   && (r_tag[w_req_idx] == w_req_tag);
    assign w_cache_rdata = r_cdata[w_lat_idx];

    assign w_wr_alloc = (r_state == S_ISSUE) && r_dram_we;
    assign w_fill     = w_done && !r_dram_we && !r_fill_kill && !w_pte_flush;

    // A flush seen while the read is outstanding makes its returning data stale.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fill_kill <= 1'b0;
        end else if (w_accept) begin
            r_fill_kill <= 1'b0;
        end else if (((r_state == S_ISSUE) || (r_state == S_WAIT)) && w_pte_flush) begin
            r_fill_kill <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid <= '0;
        end else if (w_pte_flush) begin
            r_valid <= '0;
        end else if (w_wr_alloc || w_fill) begin
            r_valid[w_lat_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr_alloc) begin
            r_tag[w_lat_idx]   <= w_lat_tag;
            r_cdata[w_lat_idx] <= r_dram_wdata;
        end else if (w_fill) begin
            r_tag[w_lat_idx]   <= w_lat_tag;
            r_cdata[w_lat_idx] <= w_dram_odata;
        end
    end
`else
    logic w_unused;

    assign w_hit         = 1'b0;
    assign w_cache_rdata = '0;
    assign w_unused      = ^{w_pte_flush, w_pte_addr[1:0], (PTE_CACHE_SIZE > 1)};
`endif

endmodule
